// File: rtl/mem_refill_arbiter.sv
// mem_refill_arbiter: round-robin arbiter that lets one cache refiller at a
// time own the downstream line-read port and forwards its beats back to it.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  S_IDLE  | no transaction; arbitrate among pending requests
//  S_REQ   | line request presented downstream, waiting for mem_gnt_i
//  S_BURST | beats passed straight through to the owning channel
//  S_DRAIN | owner aborted; remaining beats swallowed silently
module mem_refill_arbiter #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_W     = 32,
  parameter int BEAT_W     = 64,
  parameter int LINE_BYTES = 64
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NUM_CH-1:0]        req_i,
  input  logic [NUM_CH*ADDR_W-1:0] addr_i,
  input  logic [NUM_CH-1:0]        abort_i,
  output logic [NUM_CH-1:0]        grant_o,
  output logic [NUM_CH-1:0]        rep_ready_o,
  output logic [BEAT_W-1:0]        rep_word_o,
  output logic                     rep_last_o,
  output logic                     busy_o,
  output logic                     mem_req_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  input  logic                     mem_gnt_i,
  input  logic                     mem_rvalid_i,
  input  logic [BEAT_W-1:0]        mem_rdata_i
);

  localparam int BEATS = LINE_BYTES * 8 / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(LINE_BYTES - 1));

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BURST, S_DRAIN} state_e;

  state_e            state_q;
  logic [NUM_CH-1:0] grant_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [CNT_W-1:0]  beat_cnt_q;
  logic [PTR_W-1:0]  rr_ptr_q;

  logic              win_found_d;
  logic [PTR_W-1:0]  win_idx_d;
  logic [PTR_W-1:0]  rr_ptr_d;
  logic [ADDR_W-1:0] win_addr_d;
  logic              owner_abort;
  logic              beat_fwd;
  int                cand;

  // Round-robin search starting at the channel after the last owner.
  always_comb begin
    win_found_d = 1'b0;
    win_idx_d   = '0;
    cand        = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = (int'(rr_ptr_q) + i) % NUM_CH;
      if (!win_found_d && req_i[cand]) begin
        win_found_d = 1'b1;
        win_idx_d   = PTR_W'(cand);
      end
    end
  end

  assign rr_ptr_d   = PTR_W'((int'(win_idx_d) + 1) % NUM_CH);
  assign win_addr_d = addr_i[int'(win_idx_d)*ADDR_W +: ADDR_W] & LINE_MASK;

  // Only the owner may abort; grant_q is zero outside REQ/BURST so stray aborts vanish.
  assign owner_abort = |(abort_i & grant_q);
  // A beat that coincides with the owner's abort is consumed but not delivered.
  assign beat_fwd    = (state_q == S_BURST) && mem_rvalid_i && !owner_abort;

  assign rep_ready_o = beat_fwd ? grant_q : '0;
  assign rep_last_o  = beat_fwd && (beat_cnt_q == LAST_BEAT);
  assign rep_word_o  = mem_rdata_i;
  assign busy_o      = (state_q != S_IDLE);
  assign mem_req_o   = (state_q == S_REQ);
  assign grant_o     = grant_q;
  assign mem_addr_o  = mem_addr_q;

  // Transaction sequencing: arbitration, downstream handshake, beat counting.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      mem_addr_q <= '0;
      beat_cnt_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_found_d) begin
            state_q    <= S_REQ;
            grant_q    <= NUM_CH'(1) << win_idx_d;
            mem_addr_q <= win_addr_d;
            rr_ptr_q   <= rr_ptr_d;
          end
        end
        S_REQ: begin
          if (owner_abort) begin
            // Once granted downstream the line must still be drained.
            state_q    <= mem_gnt_i ? S_DRAIN : S_IDLE;
            grant_q    <= '0;
            beat_cnt_q <= '0;
          end else if (mem_gnt_i) begin
            state_q    <= S_BURST;
            beat_cnt_q <= '0;
          end
        end
        S_BURST: begin
          if (mem_rvalid_i) begin
            if (beat_cnt_q == LAST_BEAT) begin
              beat_cnt_q <= '0;
              state_q    <= S_IDLE;
              grant_q    <= '0;
            end else begin
              beat_cnt_q <= beat_cnt_q + CNT_W'(1);
              if (owner_abort) begin
                state_q <= S_DRAIN;
                grant_q <= '0;
              end
            end
          end else if (owner_abort) begin
            state_q <= S_DRAIN;
            grant_q <= '0;
          end
        end
        S_DRAIN: begin
          if (mem_rvalid_i) begin
            if (beat_cnt_q == LAST_BEAT) begin
              beat_cnt_q <= '0;
              state_q    <= S_IDLE;
            end else begin
              beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Scoreboard bench for mem_refill_arbiter: stimulus pushes expected grants
// and beats; a negedge monitor pops and compares whatever the DUT presents.
module tb_mem_refill_arbiter;
  localparam int NUM_CH     = 3;
  localparam int ADDR_W     = 32;
  localparam int BEAT_W     = 64;
  localparam int LINE_BYTES = 64;
  localparam int BEATS      = LINE_BYTES * 8 / BEAT_W;

  localparam int AB_NONE     = 0;
  localparam int AB_PRE_GNT  = 1;
  localparam int AB_WITH_GNT = 2;
  localparam int AB_ON_BEAT  = 3;
  localparam int AB_GAP      = 4;
  localparam int AB_RESET    = 5;

  logic                     clk_i = 1'b0;
  logic                     reset_i;
  logic [NUM_CH-1:0]        req_i;
  logic [NUM_CH*ADDR_W-1:0] addr_i;
  logic [NUM_CH-1:0]        abort_i;
  logic [NUM_CH-1:0]        grant_o;
  logic [NUM_CH-1:0]        rep_ready_o;
  logic [BEAT_W-1:0]        rep_word_o;
  logic                     rep_last_o;
  logic                     busy_o;
  logic                     mem_req_o;
  logic [ADDR_W-1:0]        mem_addr_o;
  logic                     mem_gnt_i;
  logic                     mem_rvalid_i;
  logic [BEAT_W-1:0]        mem_rdata_i;

  mem_refill_arbiter #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .LINE_BYTES(LINE_BYTES)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .req_i(req_i), .addr_i(addr_i),
    .abort_i(abort_i), .grant_o(grant_o), .rep_ready_o(rep_ready_o),
    .rep_word_o(rep_word_o), .rep_last_o(rep_last_o), .busy_o(busy_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int ch; logic [ADDR_W-1:0] addr; } gexp_t;
  typedef struct { int ch; logic [BEAT_W-1:0] data; bit last; } bexp_t;

  gexp_t gq[$];
  bexp_t bq[$];
  int    tests = 0;
  int    fails = 0;

  // Reference model: pending requests and the round-robin pointer.
  bit                pend[NUM_CH];
  logic [ADDR_W-1:0] paddr[NUM_CH];
  int                model_ptr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor
  logic  prev_req = 1'b0;
  gexp_t mg;
  bexp_t mb;
  always @(negedge clk_i) begin
    if (mem_req_o && !prev_req) begin
      if (gq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_grant: grant_o=%0h expected no new transaction", grant_o);
      end else begin
        mg = gq.pop_front();
        chk("grant_onehot", grant_o, 64'(1) << mg.ch);
        chk("mem_addr", mem_addr_o, mg.addr);
      end
    end
    prev_req = mem_req_o;
    if (rep_ready_o != '0) begin
      if (bq.size() == 0) begin
        tests++; fails++;
        $display("FAIL stray_beat: rep_ready_o=%0h expected 0", rep_ready_o);
      end else begin
        mb = bq.pop_front();
        chk("rep_ready", rep_ready_o, 64'(1) << mb.ch);
        chk("rep_word", rep_word_o, mb.data);
        chk("rep_last", rep_last_o, mb.last);
      end
    end else begin
      chk("rep_last_no_beat", rep_last_o, 0);
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_req();
    for (int c = 0; c < NUM_CH; c++) begin
      req_i[c] = pend[c];
      addr_i[c*ADDR_W +: ADDR_W] = paddr[c];
    end
  endtask

  // Random aborts from channels that do not own the transaction.
  task automatic noise(input int owner);
    abort_i = NUM_CH'($urandom) & ~(NUM_CH'(1) << owner);
  endtask

  function automatic int model_pick();
    for (int i = 0; i < NUM_CH; i++) begin
      int c = (model_ptr + i) % NUM_CH;
      if (pend[c]) return c;
    end
    return -1;
  endfunction

  task automatic finish_line(input int w, input bit rereq);
    pend[w] = rereq;
    if (rereq) paddr[w] = $urandom;
    drive_req();
  endtask

  task automatic do_reset();
    reset_i = 1'b0;
    mem_rvalid_i = 1'b1;
    abort_i = '0;
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_grant", grant_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_rep_ready", rep_ready_o, 0);
    chk("rst_rep_last", rep_last_o, 0);
    for (int c = 0; c < NUM_CH; c++) pend[c] = 1'b0;
    drive_req();
    model_ptr = 0;
    tick();
    tick();
    reset_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i = {$urandom, $urandom};
      tick();
    end
    mem_rvalid_i = 1'b0;
    chk("post_rst_busy", busy_o, 0);
    chk("post_rst_grant", grant_o, 0);
  endtask

  // One arbitration plus the resulting line transaction. Must be entered with
  // the DUT idle; requests set just before are sampled at the first edge.
  task automatic one_line(input int gnt_dly, input int gap, input int ab_mode,
                          input int ab_beat, input bit rereq);
    int w, n, g;
    bit aborted;
    logic [BEAT_W-1:0] d;
    w = model_pick();
    if (w < 0) return;
    model_ptr = (w + 1) % NUM_CH;
    gq.push_back('{w, paddr[w] & ~ADDR_W'(LINE_BYTES - 1)});
    mem_rvalid_i = 1'($urandom_range(0, 1));
    mem_rdata_i = {$urandom, $urandom};
    noise(w);
    tick();
    n = 0;
    while (!mem_req_o && n < 8) begin tick(); n++; end
    if (!mem_req_o) begin
      tests++; fails++;
      $display("FAIL req_timeout: mem_req_o=0 expected 1");
    end
    for (int i = 0; i < gnt_dly; i++) begin
      mem_rvalid_i = 1'($urandom_range(0, 1));
      mem_rdata_i = {$urandom, $urandom};
      mem_gnt_i = 1'b0;
      noise(w);
      tick();
    end
    mem_rvalid_i = 1'($urandom_range(0, 1));
    noise(w);
    if (ab_mode == AB_PRE_GNT) begin
      abort_i[w] = 1'b1;
      mem_gnt_i = 1'b0;
      tick();
      abort_i = '0;
      mem_rvalid_i = 1'b0;
      chk("abort_req_drop", mem_req_o, 0);
      chk("abort_busy", busy_o, 0);
      chk("abort_grant", grant_o, 0);
      finish_line(w, rereq);
      return;
    end
    mem_gnt_i = 1'b1;
    aborted = (ab_mode == AB_WITH_GNT);
    if (aborted) abort_i[w] = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      g = (gap >= 0) ? gap : $urandom_range(0, 2);
      if ((ab_mode == AB_GAP || ab_mode == AB_RESET) && b == ab_beat && g == 0) g = 1;
      for (int k = 0; k < g; k++) begin
        noise(w);
        mem_rvalid_i = 1'b0;
        mem_rdata_i = {$urandom, $urandom};
        if (k == 0 && b == ab_beat && ab_mode == AB_RESET) begin
          do_reset();
          return;
        end
        if (k == 0 && b == ab_beat && ab_mode == AB_GAP && !aborted) begin
          abort_i[w] = 1'b1;
          aborted = 1'b1;
        end
        tick();
      end
      noise(w);
      mem_rvalid_i = 1'b1;
      d = {$urandom, $urandom};
      mem_rdata_i = d;
      if (ab_mode == AB_ON_BEAT && b == ab_beat && !aborted) begin
        abort_i[w] = 1'b1;
        aborted = 1'b1;
      end else if (!aborted) begin
        bq.push_back('{w, d, (b == BEATS - 1)});
      end
      if (b == 2 && $urandom_range(0, 1) == 1) req_i[w] = 1'b0;
      tick();
    end
    mem_rvalid_i = 1'b0;
    abort_i = '0;
    chk("end_busy", busy_o, 0);
    chk("end_grant", grant_o, 0);
    chk("end_mem_req", mem_req_o, 0);
    finish_line(w, rereq);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b0;
    req_i = '0;
    addr_i = '0;
    abort_i = '0;
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 64'hDEAD_BEEF_0000_0001;
    for (int c = 0; c < NUM_CH; c++) begin pend[c] = 1'b0; paddr[c] = '0; end
    tick();
    tick();
    chk("reset_busy", busy_o, 0);
    chk("reset_grant", grant_o, 0);
    chk("reset_mem_req", mem_req_o, 0);
    chk("reset_mem_addr", mem_addr_o, 0);
    chk("reset_rep_ready", rep_ready_o, 0);
    chk("reset_rep_last", rep_last_o, 0);
    reset_i = 1'b1;
    mem_rvalid_i = 1'b0;
    tick();

    // Simultaneous ch0/ch1 after reset; ch0 re-requests and must wait for ch1.
    pend[0] = 1'b1; paddr[0] = $urandom;
    pend[1] = 1'b1; paddr[1] = $urandom;
    drive_req();
    one_line(1, -1, AB_NONE, 0, 1'b1);
    one_line(0, -1, AB_NONE, 0, 1'b0);
    one_line(2, -1, AB_NONE, 0, 1'b0);

    // Single ch0 line at 0x1234, grant after 3 cycles, back-to-back beats.
    pend[0] = 1'b1; paddr[0] = 32'h0000_1234;
    drive_req();
    one_line(3, 0, AB_NONE, 0, 1'b0);

    // ch1 owns the line and aborts after beat 3; pending ch0 goes next.
    pend[0] = 1'b1; paddr[0] = $urandom;
    pend[1] = 1'b1; paddr[1] = $urandom;
    drive_req();
    one_line(1, 0, AB_GAP, 4, 1'b0);
    one_line(0, -1, AB_NONE, 0, 1'b0);

    // Abort before downstream grant.
    pend[2] = 1'b1; paddr[2] = $urandom;
    drive_req();
    one_line(2, -1, AB_PRE_GNT, 0, 1'b0);

    // Beat every third cycle.
    pend[1] = 1'b1; paddr[1] = $urandom;
    drive_req();
    one_line(1, 2, AB_NONE, 0, 1'b0);

    // Abort together with grant, and abort on the last beat.
    pend[2] = 1'b1; paddr[2] = $urandom;
    drive_req();
    one_line(0, -1, AB_WITH_GNT, 0, 1'b0);
    pend[0] = 1'b1; paddr[0] = $urandom;
    drive_req();
    one_line(1, -1, AB_ON_BEAT, BEATS - 1, 1'b0);

    // Randomized traffic.
    for (int r = 0; r < 40; r++) begin
      int am, ab;
      for (int c = 0; c < NUM_CH; c++)
        if (!pend[c] && $urandom_range(0, 1) == 1) begin
          pend[c] = 1'b1;
          paddr[c] = $urandom;
        end
      if (model_pick() < 0) begin
        pend[r % NUM_CH] = 1'b1;
        paddr[r % NUM_CH] = $urandom;
      end
      drive_req();
      am = $urandom_range(0, 6);
      if (am > AB_GAP) am = AB_NONE;
      ab = $urandom_range(0, BEATS - 1);
      one_line($urandom_range(0, 3), -1, am, ab, 1'($urandom_range(0, 1)));
    end
    for (int r = 0; r < NUM_CH && model_pick() >= 0; r++)
      one_line(1, -1, AB_NONE, 0, 1'b0);

    // Reset in the middle of a burst, then stray beats.
    pend[1] = 1'b1; paddr[1] = $urandom;
    drive_req();
    one_line(1, 0, AB_RESET, 3, 1'b0);

    // Pointer must be back at channel 0.
    for (int c = 0; c < NUM_CH; c++) begin pend[c] = 1'b1; paddr[c] = $urandom; end
    drive_req();
    for (int c = 0; c < NUM_CH; c++) one_line(1, -1, AB_NONE, 0, 1'b0);

    tick();
    tick();
    chk("grants_outstanding", gq.size(), 0);
    chk("beats_outstanding", bq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_refill_arbiter.md
MEM_REFILL_ARBITER -- requirements
Module: mem_refill_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_CH default 2, number of refill requesters (icache, dcache, ...), range 1-8; ADDR_W default 32, byte-address width; BEAT_W default 64, refill beat width in bits; LINE_BYTES default 64, cache line size, power of two, at least BEAT_W/8.
REQ-002 Derived constant SHALL be BEATS = LINE_BYTES*8/BEAT_W, the beats per line (default 8).
REQ-003 Clocking SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk_i  in  1  sole clock, rising edge.
REQ-005 reset_i  in  1  asynchronous, active-low reset.
REQ-006 req_i  in  NUM_CH  per-channel refill request, level, held until the channel's last beat or abort.
REQ-007 addr_i  in  NUM_CH*ADDR_W  per-channel miss address, channel c at bits [c*ADDR_W +: ADDR_W].
REQ-008 abort_i  in  NUM_CH  per-channel abort pulse (branch redirect/flush).
REQ-009 grant_o  out  NUM_CH  one-hot owner of the current transaction.
REQ-010 rep_ready_o  out  NUM_CH  per-channel beat-valid strobe.
REQ-011 rep_word_o  out  BEAT_W  beat data, shared by all channels.
REQ-012 rep_last_o  out  1  marks the final beat of a line.
REQ-013 busy_o  out  1  high in any state other than IDLE.
REQ-014 mem_req_o  out  1  downstream line-read request.
REQ-015 mem_addr_o  out  ADDR_W  line-aligned downstream address.
REQ-016 mem_gnt_i  in  1  downstream accepts the request.
REQ-017 mem_rvalid_i  in  1  downstream beat valid, beats returned in order.
REQ-018 mem_rdata_i  in  BEAT_W  downstream beat data.

Function
REQ-019 The FSM SHALL have four states: IDLE, REQ, BURST, DRAIN.
REQ-020 In IDLE with any req_i bit high, the block SHALL pick a winner round-robin, starting from the channel after the last granted one (channel 0 after reset), and enter REQ on the next edge.
REQ-021 On that entry, the block SHALL latch the winner's address with its low log2(LINE_BYTES) bits cleared and drive grant_o for the winner.
REQ-022 In REQ, mem_req_o SHALL be 1 with a stable mem_addr_o; when mem_gnt_i is 1, the block SHALL enter BURST and clear the beat counter.
REQ-023 In BURST, each mem_rvalid_i SHALL produce, in the same cycle (combinational pass-through), rep_ready_o[owner]=1 and rep_word_o=mem_rdata_i, and SHALL increment the beat counter.
REQ-024 rep_last_o SHALL be 1 with the beat whose counter equals BEATS-1; after that beat, the FSM SHALL return to IDLE and grant_o SHALL clear.
REQ-025 rep_ready_o SHALL be 0 when mem_rvalid_i is 0; mem_rvalid_i in IDLE or REQ SHALL be ignored.
REQ-026 Abort in REQ before the grant SHALL drop mem_req_o and return the FSM to IDLE with no beats delivered.
REQ-027 Abort in REQ in the same cycle as mem_gnt_i SHALL send the FSM to DRAIN.
REQ-028 Abort in BURST SHALL send the FSM to DRAIN; a beat arriving in the abort cycle SHALL NOT be forwarded.
REQ-029 In DRAIN, the block SHALL consume the remaining beats with rep_ready_o all 0, then go to IDLE; grant_o SHALL clear on abort.
REQ-030 abort_i from a non-owner channel SHALL have no effect.
REQ-031 req_i deasserted by the owner mid-burst SHALL NOT stop the burst; the owner SHALL still receive all beats.
REQ-032 The round-robin pointer SHALL advance only on a grant; the channel after the last owner SHALL have top priority.
REQ-033 A new arbitration SHALL take place no earlier than the cycle after the return to IDLE, so there is one idle cycle between lines.
REQ-034 A back-to-back request from the same channel SHALL be granted again only if no other channel is requesting.
REQ-035 The beat counter SHALL be log2(BEATS) bits wide (at least 1 bit) and SHALL wrap to 0 after the last beat.

Reset
REQ-036 While reset_i is 0, the block SHALL hold: state IDLE, grant_o 0, rep_ready_o 0, rep_last_o 0, busy_o 0, mem_req_o 0, mem_addr_o 0, beat counter 0, round-robin pointer at channel 0.
REQ-037 Reset mid-burst SHALL discard the transaction immediately; beats arriving after reset release SHALL be ignored (state IDLE).
REQ-038 rep_word_o SHALL carry mem_rdata_i at all times; its value is meaningful only when a rep_ready_o bit is 1.

Verification
REQ-039 Stimulus: ch0 requests 0x0000_1234, gnt after 3 cycles, 8 consecutive beats D0-D7 -> mem_addr_o=0x0000_1200; 8 rep_ready_o[0] pulses; rep_last_o only on D7; busy_o low the cycle after.
REQ-040 Stimulus: ch0 and ch1 request in the same cycle after reset -> ch0 granted first, ch1 next; a repeat of both -> ch0 granted again only after ch1's line.
REQ-041 Stimulus: ch1 aborts after beat 3 -> beats 4-7 consumed with rep_ready_o=0; FSM in IDLE after beat 7; a pending ch0 request granted next.
REQ-042 Stimulus: abort in REQ before gnt -> mem_req_o drops the next cycle; no beats are delivered.
REQ-043 Stimulus: gaps in mem_rvalid_i (beat every 3rd cycle) -> 8 beats still delivered; the counter holds during gaps.
REQ-044 Stimulus: reset_i low mid-burst, then 3 stray rvalid beats after release -> all outputs at reset values; no rep_ready_o pulses.
